// File: rtl/spi_cfg_master.sv
// SPI master that frames (address, data) register writes for the demoscene config slave.
// Mode 0, MSB first: FLUSH pulse with SSEL high, header byte, address/data pairs, then a commit TAIL pulse.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [7:0]  HEADER    = 8'h00,
  parameter int unsigned MAX_PAIRS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  output logic       SCLK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO,
  output logic       busy,
  output logic       done,
  output logic       ack
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SETUP,
    SHIFT,
    WAIT,
    TAIL,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    BYTE_HDR,
    BYTE_ADDR,
    BYTE_DATA
  } byte_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0] PAIR_MAX = 3'(MAX_PAIRS);

  state_t     state;
  byte_t      byte_sel;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [2:0] pair_cnt;
  logic [7:0] shreg;
  logic [3:0] addr_q;
  logic [7:0] data_q;
  logic       last_q;
  logic       pair_end;

  logic       phase_end;
  logic       accept;

  always_comb begin
    phase_end = (div_cnt == DIV_LAST);
    accept    = cmd_valid & cmd_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_sel  <= BYTE_HDR;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      pair_cnt  <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      pair_end  <= 1'b0;
      cmd_ready <= 1'b0;
      SCLK      <= 1'b0;
      SSEL      <= 1'b1;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack       <= 1'b0;
    end else begin
      done    <= 1'b0;
      // Phase timer wraps every H cycles; untimed states pin it to zero so the next phase starts aligned.
      div_cnt <= phase_end ? '0 : div_cnt + 8'd1;

      case (state)
        IDLE: begin
          div_cnt   <= '0;
          cmd_ready <= 1'b1;
          if (accept) begin
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            last_q    <= cmd_last;
            pair_cnt  <= 3'd1;
            shreg     <= HEADER;
            byte_sel  <= BYTE_HDR;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            SCLK      <= 1'b1;
            state     <= FLUSH;
          end
        end

        FLUSH: begin
          if (phase_end) begin
            if (SCLK) begin
              SCLK <= 1'b0;
            end else begin
              SSEL  <= 1'b0;
              MOSI  <= shreg[7];
              state <= SETUP;
            end
          end
        end

        SETUP: begin
          if (phase_end) begin
            SCLK  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (phase_end) begin
            if (SCLK) begin
              SCLK <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], 1'b0};
                MOSI    <= shreg[6];
              end else begin
                bit_cnt <= '0;
                case (byte_sel)
                  BYTE_HDR: begin
                    shreg    <= {4'h0, addr_q};
                    MOSI     <= 1'b0;
                    byte_sel <= BYTE_ADDR;
                  end
                  BYTE_ADDR: begin
                    shreg    <= data_q;
                    MOSI     <= data_q[7];
                    byte_sel <= BYTE_DATA;
                  end
                  default: begin
                    MOSI     <= 1'b0;
                    pair_end <= 1'b1;
                  end
                endcase
              end
            end else if (pair_end) begin
              // The data byte's low phase has elapsed; either close the frame or park for the next pair.
              pair_end <= 1'b0;
              if (last_q || (pair_cnt == PAIR_MAX)) begin
                SCLK  <= 1'b1;
                ack   <= MISO;
                state <= TAIL;
              end else begin
                cmd_ready <= 1'b1;
                state     <= WAIT;
              end
            end else begin
              SCLK <= 1'b1;
            end
          end
        end

        WAIT: begin
          div_cnt <= '0;
          if (accept) begin
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            last_q    <= cmd_last;
            pair_cnt  <= pair_cnt + 3'd1;
            shreg     <= {4'h0, cmd_addr};
            byte_sel  <= BYTE_ADDR;
            bit_cnt   <= '0;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end

        TAIL: begin
          if (phase_end) begin
            if (SCLK) begin
              SCLK <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (phase_end) begin
            SSEL  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
